// File: rtl/axi_rd_arbiter_if.sv
// Bundle of the two cache refill request ports and the AXI AR/R channels
// seen by axi_rd_arbiter (master) and its environment (slave).
interface axi_rd_arbiter_if;
  logic        i_req_valid, d_req_valid;
  logic [31:0] i_req_addr,  d_req_addr;
  logic [3:0]  i_req_len,   d_req_len;
  logic [2:0]  i_req_size,  d_req_size;
  logic        i_req_ready, d_req_ready;
  logic        i_rvalid,    d_rvalid;
  logic        i_rlast,     d_rlast;
  logic        i_rerr,      d_rerr;
  logic [31:0] r_data_o;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    input  i_req_valid, d_req_valid, i_req_addr, d_req_addr,
           i_req_len, d_req_len, i_req_size, d_req_size,
    output i_req_ready, d_req_ready, i_rvalid, d_rvalid,
           i_rlast, d_rlast, i_rerr, d_rerr, r_data_o,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output i_req_valid, d_req_valid, i_req_addr, d_req_addr,
           i_req_len, d_req_len, i_req_size, d_req_size,
    input  i_req_ready, d_req_ready, i_rvalid, d_rvalid,
           i_rlast, d_rlast, i_rerr, d_rerr, r_data_o,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read port between I-cache and D-cache
// refills; one burst outstanding at a time, beat count decides burst end.
module axi_rd_arbiter #(
  parameter logic [3:0] I_ID = 4'd0,
  parameter logic [3:0] D_ID = 4'd1
) (
  input  logic               clk,
  input  logic               reset,
  output logic               busy,
  axi_rd_arbiter_if.master   bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state, state_nxt;
  logic        last_grant_d;
  logic        owner_d;
  logic [31:0] ar_addr;
  logic [3:0]  ar_len;
  logic [2:0]  ar_size;
  logic [3:0]  beat_cnt;

  logic        grant_i, grant_d;
  logic        beat, last_beat, beat_err;
  logic [3:0]  owner_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    beat        = 1'b0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so no grant is visible while reset is held.
        grant_d = !reset && bus.d_req_valid && (!bus.i_req_valid || !last_grant_d);
        grant_i = !reset && bus.i_req_valid && !grant_d;
        if (grant_i || grant_d) state_nxt = ADDR;
      end
      ADDR: begin
        bus.arvalid = 1'b1;
        if (bus.arready) state_nxt = DATA;
      end
      DATA: begin
        bus.rready = 1'b1;
        beat       = bus.rvalid;
        if (beat && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_d <= 1'b0;
      owner_d      <= 1'b0;
      ar_addr      <= '0;
      ar_len       <= '0;
      ar_size      <= '0;
      beat_cnt     <= '0;
    end else begin
      if (grant_i || grant_d) begin
        last_grant_d <= grant_d;
        owner_d      <= grant_d;
        ar_addr      <= grant_d ? bus.d_req_addr : bus.i_req_addr;
        ar_len       <= grant_d ? bus.d_req_len  : bus.i_req_len;
        ar_size      <= grant_d ? bus.d_req_size : bus.i_req_size;
      end
      if (state == ADDR && bus.arready) beat_cnt <= '0;
      else if (beat)                    beat_cnt <= beat_cnt + 4'd1;
    end
  end

  assign owner_id  = owner_d ? D_ID : I_ID;
  assign last_beat = (beat_cnt == ar_len);
  // AXI rlast is only cross-checked against the counter, never trusted.
  assign beat_err  = (bus.rresp != 2'b00) || (bus.rid != owner_id) || (bus.rlast != last_beat);

  assign bus.i_req_ready = grant_i;
  assign bus.d_req_ready = grant_d;
  assign bus.i_rvalid    = beat && !owner_d;
  assign bus.d_rvalid    = beat &&  owner_d;
  assign bus.i_rlast     = beat && !owner_d && last_beat;
  assign bus.d_rlast     = beat &&  owner_d && last_beat;
  assign bus.i_rerr      = beat && !owner_d && beat_err;
  assign bus.d_rerr      = beat &&  owner_d && beat_err;
  assign bus.r_data_o    = beat ? bus.rdata : '0;

  assign bus.arid    = owner_id;
  assign bus.araddr  = ar_addr;
  assign bus.arlen   = ar_len;
  assign bus.arsize  = ar_size;
  assign bus.arburst = 2'b01;

  assign busy = (state != IDLE);

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameters SHALL be: I_ID, default 4'd0, ARID used for I-cache grants; D_ID, default 4'd1, ARID used for D-cache grants.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 i_req_valid / d_req_valid  in  1 each  refill request pending from I-cache / D-cache.
REQ-005 i_req_addr / d_req_addr  in  32 each  burst start physical address.
REQ-006 i_req_len / d_req_len  in  4 each  AXI arlen (beats-1).
REQ-007 i_req_size / d_req_size  in  3 each  AXI arsize.
REQ-008 i_req_ready / d_req_ready  out  1 each  request accepted this cycle.
REQ-009 i_rvalid / d_rvalid  out  1 each  returned beat valid for that requester.
REQ-010 i_rlast / d_rlast / i_rerr / d_rerr  out  1 each  final beat; error (rresp!=0 or rlast/beat-count mismatch).
REQ-011 r_data_o  out  32  beat data, shared by both requesters.
REQ-012 arid 4, araddr 32, arlen 4, arsize 3, arburst 2, arvalid 1  out  AXI AR channel; arburst fixed 2'b01 (INCR).
REQ-013 arready  in  1; rid 4, rdata 32, rresp 2, rlast 1, rvalid 1  in; rready  out  1  AXI R channel.
REQ-014 busy  out  1  high in any state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ADDR, DATA; reset state IDLE.
REQ-016 IDLE: if any req_valid, grant one requester, assert its req_ready for exactly that cycle, latch addr/len/size/owner into AR registers, go to ADDR next cycle.
REQ-017 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last; last_grant resets to I-cache (so D-cache wins the first tie).
REQ-018 Single requester SHALL be granted regardless of last_grant.
REQ-019 req_ready SHALL never be asserted outside IDLE; at most one req_ready high per cycle.
REQ-020 ADDR: arvalid=1 with latched araddr/arlen/arsize and arid=owner ID; AR fields SHALL be stable while arvalid=1 and arready=0; on arvalid&&arready go to DATA, clear beat counter.
REQ-021 DATA: rready=1; each rvalid beat SHALL assert owner's rvalid combinationally in the same cycle with r_data_o=rdata; non-owner rvalid stays 0.
REQ-022 A beat with rid != owner ID SHALL be accepted (rready high) and flagged via owner's rerr on that beat.
REQ-023 4-bit beat counter increments per accepted beat; beat with counter==latched len SHALL assert owner's rlast regardless of AXI rlast.
REQ-024 Owner's rerr SHALL assert on any beat with rresp!=0, or where AXI rlast disagrees with (counter==len).
REQ-025 After the beat where counter==len, FSM SHALL return to IDLE next cycle; new grant possible that same IDLE cycle (one-cycle bubble minimum between bursts).
REQ-026 AXI rlast arriving early SHALL NOT terminate the burst; only the counter ends it.
REQ-027 rready SHALL be 0 in IDLE and ADDR; rvalid seen there SHALL be ignored.
REQ-028 Only one transaction outstanding at any time; no AR issued while in DATA.

Reset
REQ-029 While reset high: state=IDLE, arvalid=0, rready=0, all req_ready/rvalid/rlast/rerr=0, busy=0, beat counter=0, last_grant=I-cache, AR registers=0.
REQ-030 Reset asserted mid-ADDR or mid-DATA SHALL abort immediately; no beat delivered to requesters after reset asserts.

Verification
REQ-031 d_req_valid only, addr=0x1FC0_0040, len=3, size=2, arready after 2 cycles -> d_req_ready pulse 1 cycle, arid=1, arlen=3, arvalid held 2 cycles; 4 beats to d_rvalid, d_rlast on beat 4, i_rvalid never high.
REQ-032 i and d request same cycle from reset -> D granted first (arid=1), then I (arid=0) after D burst + 1 idle cycle; repeat simultaneous -> grants alternate I, D, I.
REQ-033 Burst len=7 with rresp=2'b10 on beat 3 -> owner rerr high only on beat 3; burst completes with 8 beats, rlast on beat 8.
REQ-034 len=3 with AXI rlast on beat 2 -> rerr on beats 2 and 4, burst continues to beat 4, owner rlast on beat 4 only.
REQ-035 Reset pulse during DATA after beat 1 of 4 -> all outputs 0 next edge, state IDLE, remaining rvalid beats produce no requester rvalid; subsequent request granted normally with I-cache last_grant.
